// File: rtl/lighthouse_emitter.sv
// Lighthouse-style photodiode envelope generator: sync pulse whose width encodes {data,rotor}, then a sweep hit.
// Optional OOTX payload shifter is compiled in with `define LH_OOTX_EN.
module lighthouse_emitter #(
  parameter int unsigned TICKS_PER_US = 50,
  parameter int unsigned FRAME_US     = 8333,
  parameter int unsigned SYNC_BASE_US = 63,
  parameter int unsigned SYNC_STEP_US = 10,
  parameter int unsigned SWEEP_W_US   = 10,
  parameter int unsigned GAP_MIN_US   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [13:0] sweep_offset_0,
  input  logic [13:0] sweep_offset_1,
  input  logic [31:0] ootx_word,
  input  logic        ootx_valid,
  output logic        ootx_ready,
  output logic        sensor_signal,
  output logic        frame_start,
  output logic        rotor,
  output logic        busy
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_US - 1);
  localparam logic [13:0]   FRAME_LAST = 14'(FRAME_US - 1);
  localparam logic [14:0]   FRAME_15   = 15'(FRAME_US);
  localparam logic [14:0]   BASE_15    = 15'(SYNC_BASE_US);
  localparam logic [14:0]   STEP_15    = 15'(SYNC_STEP_US);
  localparam logic [14:0]   SWEEP_15   = 15'(SWEEP_W_US);
  localparam logic [14:0]   GAP_15     = 15'(GAP_MIN_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT_HIT,
    S_HIT,
    S_WAIT_END
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [13:0]   us_cnt_q;
  logic [13:0]   off_q;
  logic          rotor_q;
  logic          data_q;
  logic          sensor_q, sensor_d;
  logic          fs_q;

  logic          us_tick;
  logic [14:0]   us_next;
  logic [14:0]   sync_w;
  logic [14:0]   hit_end;
  logic          suppress;
  logic          frame_end;
  logic          start_frame;
  logic          toggle_rotor;
  logic          rotor_next;
  logic          data_bit;

  assign us_tick   = (state_q != S_IDLE) && (presc_q == PRESC_MAX);
  assign us_next   = {1'b0, us_cnt_q} + 15'd1;
  assign sync_w    = BASE_15 + STEP_15 * 15'({data_q, rotor_q});
  assign hit_end   = {1'b0, off_q} + SWEEP_15;
  assign suppress  = ({1'b0, off_q} < (sync_w + GAP_15)) || (hit_end >= FRAME_15);
  assign frame_end = us_tick && (us_cnt_q == FRAME_LAST);

  // Edges are scheduled on the tick where us_cnt becomes the target, so pulse timing is exact in us.
  always_comb begin
    state_d      = state_q;
    sensor_d     = sensor_q;
    start_frame  = 1'b0;
    toggle_rotor = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_SYNC;
          sensor_d    = 1'b1;
          start_frame = 1'b1;
        end
      end
      S_SYNC: begin
        if (us_tick && (us_next == sync_w)) begin
          sensor_d = 1'b0;
          state_d  = suppress ? S_WAIT_END : S_WAIT_HIT;
        end
      end
      S_WAIT_HIT: begin
        if (us_tick && (us_next == {1'b0, off_q})) begin
          sensor_d = 1'b1;
          state_d  = S_HIT;
        end
      end
      S_HIT: begin
        if (us_tick && (us_next == hit_end)) begin
          sensor_d = 1'b0;
          state_d  = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (frame_end) begin
          toggle_rotor = 1'b1;
          if (enable) begin
            state_d     = S_SYNC;
            sensor_d    = 1'b1;
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        sensor_d = 1'b0;
      end
    endcase
  end

  assign rotor_next = toggle_rotor ? ~rotor_q : rotor_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      us_cnt_q <= '0;
      off_q    <= '0;
      rotor_q  <= 1'b0;
      data_q   <= 1'b0;
      sensor_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sensor_q <= sensor_d;
      fs_q     <= start_frame;
      rotor_q  <= rotor_next;
      if (start_frame || (state_d == S_IDLE) || (presc_q == PRESC_MAX)) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      if (start_frame || (state_d == S_IDLE)) begin
        us_cnt_q <= '0;
      end else if (us_tick) begin
        us_cnt_q <= us_next[13:0];
      end
      // Offsets and the data bit are frozen for the whole frame.
      if (start_frame) begin
        off_q  <= rotor_next ? sweep_offset_1 : sweep_offset_0;
        data_q <= data_bit;
      end
    end
  end

`ifdef LH_OOTX_EN
  // ootx_word transfers on any cycle where ootx_valid && ootx_ready are both high at the rising clk edge;
  // ootx_ready is high exactly while the shifter is empty and does not depend on ootx_valid.
  logic [31:0] shreg_q;
  logic [5:0]  bits_q;

  assign ootx_ready = (bits_q == 6'd0);
  assign data_bit   = (bits_q != 6'd0) ? shreg_q[31] : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      bits_q  <= '0;
    end else if (ootx_valid && ootx_ready) begin
      shreg_q <= ootx_word;
      bits_q  <= 6'd32;
    end else if (start_frame && (bits_q != 6'd0)) begin
      shreg_q <= {shreg_q[30:0], 1'b0};
      bits_q  <= bits_q - 6'd1;
    end
  end
`else
  logic unused_ootx;
  assign unused_ootx = ^{ootx_word, ootx_valid};
  assign ootx_ready  = 1'b0;
  assign data_bit    = 1'b0;
`endif

  assign sensor_signal = sensor_q;
  assign frame_start   = fs_q;
  assign rotor         = rotor_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_lighthouse_emitter.sv
// Scoreboard bench for lighthouse_emitter: stimulus pushes expected pulses, a monitor measures and compares them.
// Runs with a shortened timebase (2 clk/us, 300 us frames); define LH_OOTX_EN to add the payload scenario.
module tb_lighthouse_emitter;

  localparam int T    = 2;
  localparam int F    = 300;
  localparam int BASE = 63;
  localparam int STEP = 10;
  localparam int SWW  = 10;
  localparam int W    = 42;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] sweep_offset_0 = '0;
  logic [13:0] sweep_offset_1 = '0;
  logic [31:0] ootx_word = '0;
  logic        ootx_valid = 1'b0;
  logic        ootx_ready;
  logic        sensor_signal;
  logic        frame_start;
  logic        rotor;
  logic        busy;

  lighthouse_emitter #(
    .TICKS_PER_US(T),
    .FRAME_US    (F),
    .SYNC_BASE_US(BASE),
    .SYNC_STEP_US(STEP),
    .SWEEP_W_US  (SWW),
    .GAP_MIN_US  (20)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sweep_offset_0(sweep_offset_0),
    .sweep_offset_1(sweep_offset_1),
    .ootx_word     (ootx_word),
    .ootx_valid    (ootx_valid),
    .ootx_ready    (ootx_ready),
    .sensor_signal (sensor_signal),
    .frame_start   (frame_start),
    .rotor         (rotor),
    .busy          (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  // entry: {frame_start_at_rise, rotor, rise (gap since previous frame_start, or offset in frame), width}, cycles
  logic [W-1:0] exp_q[$];

`ifdef LH_OOTX_EN
  localparam logic EXP_READY = 1'b1;
`else
  localparam logic EXP_READY = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_start(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < limit);
    check("frame_start_seen", 64'(frame_start), 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic push_frame(input logic rot, input int sw_us, input int off_us, input bit hit, input int gap);
    exp_q.push_back({1'b1, rot, 20'(gap), 20'(sw_us * T)});
    if (hit) exp_q.push_back({1'b0, rot, 20'(off_us * T), 20'(SWW * T)});
  endtask

  // monitor
  logic in_pulse = 1'b0, have_prev = 1'b0, idle_seen = 1'b1, fs_prev = 1'b0;
  logic rise_fs, rise_rot;
  int   prev_fs = 0, gap = 0, rise_cyc = 0, rise_rel = 0;
  logic [W-1:0] got;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_pulse  = 1'b0;
      have_prev = 1'b0;
      idle_seen = 1'b1;
      fs_prev   = 1'b0;
    end else begin
      if (fs_prev) check("frame_start_one_cycle", 64'(frame_start), 64'd0);
      fs_prev = frame_start;
      if (frame_start) begin
        gap       = (have_prev && !idle_seen) ? cyc - prev_fs : 0;
        prev_fs   = cyc;
        have_prev = 1'b1;
        idle_seen = 1'b0;
      end else if (!busy) begin
        idle_seen = 1'b1;
      end
      if (sensor_signal && !in_pulse) begin
        in_pulse = 1'b1;
        rise_cyc = cyc;
        rise_fs  = frame_start;
        rise_rot = rotor;
        rise_rel = frame_start ? gap : cyc - prev_fs;
      end else if (!sensor_signal && in_pulse) begin
        in_pulse = 1'b0;
        got = {rise_fs, rise_rot, 20'(rise_rel), 20'(cyc - rise_cyc)};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got 0x%0h expected none", got);
        end else begin
          check("pulse", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // reset state
    wait_cycles(3);
    check("rst_sensor", 64'(sensor_signal), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ootx_ready", 64'(ootx_ready), 64'(EXP_READY));
    reset_n = 1'b1;
    wait_cycles(200);
    check("idle_no_activity", 64'({busy, rotor, sensor_signal}), 64'd0);

    // basic frames: offsets 200/150, enable dropped at us 100 of frame 3
    sweep_offset_0 = 14'd200;
    sweep_offset_1 = 14'd150;
    push_frame(1'b0, 63, 200, 1'b1, 0);
    push_frame(1'b1, 73, 150, 1'b1, F * T);
    push_frame(1'b0, 63, 200, 1'b1, F * T);
    push_frame(1'b1, 73, 150, 1'b1, F * T);
    enable = 1'b1;
    wait_frame_start(20);
    wait_cycles((3 * F + 100) * T);
    check("busy_mid_frame", 64'(busy), 64'd1);
    check("rotor_frame3", 64'(rotor), 64'd1);
    enable = 1'b0;
    wait_idle(F * T + 20);
    check("rotor_after_stop", 64'(rotor), 64'd0);
    wait_cycles(2 * F * T);
    check("no_sync_after_stop", 64'(busy), 64'd0);
    check("sb_drained_basic", 64'(exp_q.size()), 64'd0);

    // suppression bounds and mid-frame offset changes
    sweep_offset_0 = 14'd70;
    sweep_offset_1 = 14'd290;
    push_frame(1'b0, 63, 70, 1'b0, 0);
    push_frame(1'b1, 73, 290, 1'b0, F * T);
    push_frame(1'b0, 63, 83, 1'b1, F * T);
    push_frame(1'b1, 73, 289, 1'b1, F * T);
    enable = 1'b1;
    wait_frame_start(20);
    wait_cycles((F + 50) * T);
    sweep_offset_0 = 14'd83;
    sweep_offset_1 = 14'd289;
    wait_cycles((2 * F + 50) * T);
    enable = 1'b0;
    wait_idle(F * T + 20);
    check("sb_drained_bounds", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in the middle of a hit pulse
    sweep_offset_0 = 14'd200;
    push_frame(1'b0, 63, 200, 1'b0, 0);
    enable = 1'b1;
    wait_frame_start(20);
    wait_cycles(205 * T);
    check("hit_high_before_reset", 64'(sensor_signal), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("async_reset_sensor", 64'(sensor_signal), 64'd0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);
    check("post_reset_outputs", 64'({sensor_signal, frame_start, rotor, busy}), 64'd0);
    check("post_reset_ready", 64'(ootx_ready), 64'(EXP_READY));
    wait_cycles(2 * F * T);
    check("post_reset_idle", 64'(busy), 64'd0);
    check("sb_drained_reset", 64'(exp_q.size()), 64'd0);

`ifdef LH_OOTX_EN
    // payload 0xA0000000: codes {d,r} = 10,01,10,01 then 00/01 for the remaining frames
    ootx_word  = 32'hA000_0000;
    ootx_valid = 1'b1;
    wait_cycles(1);
    ootx_valid = 1'b0;
    check("ootx_loaded", 64'(ootx_ready), 64'd0);
    push_frame(1'b0, 83, 200, 1'b1, 0);
    push_frame(1'b1, 73, 150, 1'b1, F * T);
    push_frame(1'b0, 83, 200, 1'b1, F * T);
    push_frame(1'b1, 73, 150, 1'b1, F * T);
    for (int k = 4; k < 32; k++) begin
      push_frame(k[0], (k % 2 == 0) ? 63 : 73, (k % 2 == 0) ? 200 : 150, 1'b1, F * T);
    end
    enable = 1'b1;
    wait_frame_start(20);
    wait_cycles((30 * F + 100) * T);
    check("ootx_busy_frame30", 64'(ootx_ready), 64'd0);
    wait_cycles(F * T);
    check("ootx_empty_frame31", 64'(ootx_ready), 64'd1);
    enable = 1'b0;
    wait_idle(F * T + 20);
    check("sb_drained_ootx", 64'(exp_q.size()), 64'd0);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
